multicycle_control: RTL



---
 rtl/multicycle_control_if.sv | 34 +++
 rtl/multicycle_control.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle control FSM (master) and the datapath (slave).
// The opcode and stall inputs travel with the control lines they steer.
interface multicycle_control_if;
  logic [6:0]  opcode;
  logic        stall;
  logic [1:0]  ALUop;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic        PCSource;
  logic        MemRead;
  logic        MemWrite;
  logic        IorD;
  logic        IRWrite;
  logic        MemtoReg;
  logic        RegWrite;
  logic        PCWrite;
  logic        PCWriteCond;
  logic [3:0]  state;
  logic        instr_done;
  logic        illegal_op;
  logic [31:0] retired;

  modport master (
    input  opcode, stall,
    output ALUop, ALUSrcA, ALUSrcB, PCSource, MemRead, MemWrite, IorD, IRWrite,
           MemtoReg, RegWrite, PCWrite, PCWriteCond, state, instr_done, illegal_op, retired
  );

  modport slave (
    output opcode, stall,
    input  ALUop, ALUSrcA, ALUSrcB, PCSource, MemRead, MemWrite, IorD, IRWrite,
           MemtoReg, RegWrite, PCWrite, PCWriteCond, state, instr_done, illegal_op, retired
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle RISC-V core: sequences fetch/decode/execute/
// memory/write-back for LW, SW, R-type and BEQ, and counts retired instructions.
module multicycle_control (
  input logic                 clk,
  input logic                 rst_n,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_RTYPEWB  = 4'd7,
    S_BRANCH   = 4'd8
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_retired;

  logic [1:0]  w_alu_op;
  logic        w_alu_src_a;
  logic [1:0]  w_alu_src_b;
  logic        w_pc_source;
  logic        w_mem_read;
  logic        w_mem_write;
  logic        w_i_or_d;
  logic        w_ir_write;
  logic        w_mem_to_reg;
  logic        w_reg_write;
  logic        w_pc_write;
  logic        w_pc_write_cond;
  logic        w_final;
  logic        w_illegal;
  logic        w_strobe_en;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else if (!bus.stall) begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired <= 32'd0;
    end else if (w_final && !bus.stall) begin
      r_retired <= r_retired + 32'd1;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_next          = S_FETCH;
    w_alu_op        = 2'b00;
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = 2'b00;
    w_pc_source     = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_i_or_d        = 1'b0;
    w_ir_write      = 1'b0;
    w_mem_to_reg    = 1'b0;
    w_reg_write     = 1'b0;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_final         = 1'b0;
    w_illegal       = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_ir_write  = 1'b1;
        w_alu_src_b = 2'b01;
        w_pc_write  = 1'b1;
        w_next      = S_DECODE;
      end
      S_DECODE: begin
        w_alu_src_b = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_next      = (bus.opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_mem_read = 1'b1;
        w_i_or_d   = 1'b1;
        w_next     = S_MEMWB;
      end
      S_MEMWB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_final      = 1'b1;
      end
      S_MEMWRITE: begin
        w_mem_write = 1'b1;
        w_i_or_d    = 1'b1;
        w_final     = 1'b1;
      end
      S_EXECUTE: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 2'b10;
        w_next      = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        w_reg_write = 1'b1;
        w_final     = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a     = 1'b1;
        w_alu_op        = 2'b01;
        w_pc_write_cond = 1'b1;
        w_pc_source     = 1'b1;
        w_final         = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Reset blanks every output at once, even though the state register already reads FETCH.
  assign w_strobe_en = rst_n & ~bus.stall;

  assign bus.ALUop       = rst_n ? w_alu_op    : 2'b00;
  assign bus.ALUSrcA     = rst_n & w_alu_src_a;
  assign bus.ALUSrcB     = rst_n ? w_alu_src_b : 2'b00;
  assign bus.PCSource    = rst_n & w_pc_source;
  assign bus.MemRead     = rst_n & w_mem_read;
  assign bus.IorD        = rst_n & w_i_or_d;
  assign bus.MemtoReg    = rst_n & w_mem_to_reg;
  assign bus.MemWrite    = w_strobe_en & w_mem_write;
  assign bus.IRWrite     = w_strobe_en & w_ir_write;
  assign bus.RegWrite    = w_strobe_en & w_reg_write;
  assign bus.PCWrite     = w_strobe_en & w_pc_write;
  assign bus.PCWriteCond = w_strobe_en & w_pc_write_cond;
  assign bus.instr_done  = w_strobe_en & w_final;
  assign bus.illegal_op  = w_strobe_en & w_illegal;
  assign bus.state       = r_state;
  assign bus.retired     = r_retired;

endmodule
